spike_aer_encoder: RTL and testbench
====================================

Name: spike_aer_encoder

Overview:
- Downstream consumer of the LIF neuron `spike` outputs; N neurons feed one encoder.
- Converts each spike into an address-event word {timestamp, neuron address}.
- Buffers events in a small first-word-fall-through (FWFT) FIFO.
- Presents events on a valid/ready stream to the output/readout logic.

Parameters:
- N_NEURONS, 4, number of spike inputs (2..16).
- ADDR_W, 2, neuron address width; equals ceil(log2(N_NEURONS)).
- TS_W, 6, timestamp counter width.
- FIFO_DEPTH, 8, event FIFO entries; power of two.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- en  in  1  capture enable; also gates the timestamp counter.
- spike_in  in  N_NEURONS  one bit per LIF neuron; a high bit is one event that cycle.
- ev_data  out  TS_W+ADDR_W  event word {ts[TS_W-1:0], addr[ADDR_W-1:0]}.
- ev_valid  out  1  head event available.
- ev_ready  in  1  consumer accepts head event.
- fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: at least one event dropped.
- drop_cnt  out  8  count of dropped events; saturates at 255.
- clr_flags  in  1  synchronous clear of overflow and drop_cnt.

Behaviour:
- Reset (rst_n low, async):
  - Timestamp counter, all pending bits, captured timestamps, FIFO pointers and count cleared.
  - ev_valid=0, ev_data=0, fifo_count=0, overflow=0, drop_cnt=0.
  - Reset mid-operation discards all buffered and pending events with no output.
- Timestamp counter ts:
  - Increments by 1 on every clk edge with en=1; wraps from 2^TS_W-1 to 0.
  - Holds when en=0.
- Capture stage (per neuron i, at each edge with en=1 and spike_in[i]=1):
  - If pending[i]=0, or pending[i] is being pushed this same edge: set pending[i]=1 and latch ts_cap[i]=ts (pre-increment value).
  - Otherwise the event is dropped: overflow<=1, drop_cnt<=sat(drop_cnt+1).
  - Several drops on one edge add their count, saturating at 255.
  - en=0: spike_in ignored; pending events still drain.
- Arbitration/push stage, one push per edge:
  - Selects the lowest-index set pending bit.
  - Writes {ts_cap[i], i} into the FIFO and clears pending[i].
  - Push allowed when count<FIFO_DEPTH, or when a pop happens on the same edge.
  - When blocked, pending is held; no loss until the same neuron spikes again.
- FIFO (FWFT):
  - ev_data always shows the head entry; ev_valid = (count!=0).
  - Pop on the edge where ev_valid && ev_ready.
  - Simultaneous push and pop leaves count unchanged.
  - ev_data and ev_valid stay stable while ev_valid=1 and ev_ready=0.
- Latency:
  - Spike sampled at edge k with an empty FIFO and no other pending neuron gives ev_valid=1 after edge k+1.
  - Throughput: 1 event/cycle.
- clr_flags: clears overflow and drop_cnt at the edge. A drop on the same edge wins: overflow=1, drop_cnt=1.
- Arithmetic: all counters unsigned; no signed math.

Decomposition:
- Shared package/include `lif_pkg`:
  - ADDR_W derivation function (clog2).
  - Event word field offsets (TS_LSB=ADDR_W).
  - Default N_NEURONS, TS_W, FIFO_DEPTH.
  - The LIF neuron and this encoder both use it.
- Sub-module `sync_fifo`:
  - Parameterised width/depth, FWFT, async active-low reset.
  - Provides count, full, empty.
- Encoder top holds the ts counter, pending/ts_cap registers, priority arbiter and drop logic.

Test Plan:
- Single spike: reset, en=1, ev_ready=1, spike_in=4'b0100 for one cycle at ts=5 -> ev_valid high exactly one cycle after the capture edge, ev_data={6'd5,2'd2}, fifo_count returns to 0.
- Simultaneous spikes: spike_in=4'b1011 at ts=10, ev_ready=1 -> three events on consecutive cycles, addr 0, 1, 3, all with ts=10, no drops.
- Backpressure: ev_ready=0, neuron 0 spikes on 9 separated cycles -> FIFO holds 8 and the 9th waits in pending, ev_data stable. A 10th spike on neuron 0 -> overflow=1, drop_cnt=1. Then ev_ready=1 -> 9 events, ts in order.
- Timestamp wrap: en=1 for 64+3 cycles, spike on neuron 1 at cycle 66 -> event ts=2. With en=0, spikes produce no events and ts holds.
- Flag clear vs drop: drop_cnt forced to 255 via repeated drops stays at 255. clr_flags with no drop -> 0. clr_flags together with a drop -> overflow=1, drop_cnt=1.
- Async reset mid-stream: assert rst_n low mid-cycle with 5 events queued -> ev_valid, fifo_count, overflow drop to 0 immediately, no events after release.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron array and the spike AER encoder:
// default sizes, address-width derivation, event word layout and the
// saturating drop-counter helper.
package lif_pkg;

  localparam int N_NEURONS_DEF  = 4;
  localparam int TS_W_DEF       = 6;
  localparam int FIFO_DEPTH_DEF = 8;

  // Drop counter is a fixed 8-bit saturating counter.
  localparam int DROP_CNT_W = 8;

  // Number of address bits needed to name n neurons (at least one bit).
  function automatic int addr_w_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Event word is {ts, addr}; the timestamp field starts right above the address.
  function automatic int ts_lsb_f(input int addr_w);
    return addr_w;
  endfunction

  // Add a small count to the drop counter, clamping at all-ones.
  function automatic logic [DROP_CNT_W-1:0] drop_sat_add(
    input logic [DROP_CNT_W-1:0] base,
    input logic [4:0]            inc
  );
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, base} + (DROP_CNT_W+1)'(inc);
    return sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : sum[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is always visible
// on rdata (zero when empty). A push while full is accepted only if a pop
// happens on the same edge; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage array; not reset because rdata is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keeps count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike-to-address-event encoder. Each neuron has a one-deep pending slot
// holding the timestamp of its latest spike; a fixed-priority arbiter moves
// one pending event per cycle into an FWFT FIFO that feeds the output stream.
//
// Output handshake: ev_valid/ev_data describe the FIFO head; the event is
// transferred on a clk edge where ev_valid && ev_ready. While ev_valid is high
// and ev_ready low, ev_valid and ev_data hold steady. ev_valid never depends
// on ev_ready.
module spike_aer_encoder
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = N_NEURONS_DEF,
  parameter int ADDR_W     = addr_w_f(N_NEURONS),
  parameter int TS_W       = TS_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int EV_W      = TS_W + ADDR_W,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [N_NEURONS-1:0]  spike_in,
  output logic [EV_W-1:0]       ev_data,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  clr_flags
);

  localparam int TS_LSB = ts_lsb_f(ADDR_W);

  logic [TS_W-1:0]      ts;
  logic [N_NEURONS-1:0] pending;
  logic [TS_W-1:0]      ts_cap [N_NEURONS];

  logic [ADDR_W-1:0]    sel;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 push_ok;
  logic [N_NEURONS-1:0] push_mask;
  logic [N_NEURONS-1:0] set_mask;
  logic [N_NEURONS-1:0] drop_mask;
  logic [4:0]           n_drop;
  logic [EV_W-1:0]      push_data;

  assign ev_valid = !fifo_empty;
  assign pop      = ev_valid && ev_ready;
  // A full FIFO still takes a push if the head leaves on the same edge.
  assign push_ok  = (|pending) && (!fifo_full || pop);

  // Fixed-priority arbiter: lowest-index pending neuron wins.
  always_comb begin
    sel = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (pending[i]) sel = ADDR_W'(i);
    end
  end

  // One-hot of the neuron being pushed this edge and the event word it forms.
  always_comb begin
    push_mask = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      push_mask[i] = push_ok && (sel == ADDR_W'(i));
    end
    push_data                    = '0;
    push_data[TS_LSB +: TS_W]    = ts_cap[sel];
    push_data[ADDR_W-1:0]        = sel;
  end

  // Capture decision: a slot accepts a spike if it is free or being emptied
  // this edge; otherwise the spike is dropped and counted.
  always_comb begin
    set_mask  = '0;
    drop_mask = '0;
    n_drop    = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (en && spike_in[i]) begin
        if (!pending[i] || push_mask[i]) set_mask[i]  = 1'b1;
        else                             drop_mask[i] = 1'b1;
      end
      n_drop = n_drop + 5'(drop_mask[i]);
    end
  end

  // Timestamp counter; free-running modulo 2^TS_W while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else if (en) ts <= ts + 1'b1;
  end

  // Pending slots and their captured (pre-increment) timestamps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      for (int i = 0; i < N_NEURONS; i++) ts_cap[i] <= '0;
    end else begin
      pending <= (pending & ~push_mask) | set_mask;
      for (int i = 0; i < N_NEURONS; i++) begin
        if (set_mask[i]) ts_cap[i] <= ts;
      end
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (n_drop != '0) begin
      overflow <= 1'b1;
      drop_cnt <= drop_sat_add(clr_flags ? '0 : drop_cnt, n_drop);
    end else if (clr_flags) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .wdata (push_data),
    .pop   (pop),
    .rdata (ev_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Bench for spike_aer_encoder: randomized and directed stimulus, an
// event-level reference model feeding an expected queue, and a negedge monitor.
module tb_spike_aer_encoder;

  localparam int N      = 4;
  localparam int ADDR_W = 2;
  localparam int TS_W   = 6;
  localparam int DEPTH  = 8;
  localparam int EW     = TS_W + ADDR_W;
  localparam int TS_MOD = 64;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic [N-1:0]  spike_in = '0;
  logic [EW-1:0] ev_data;
  logic          ev_valid;
  logic          ev_ready = 1'b0;
  logic [3:0]    fifo_count;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          clr_flags = 1'b0;

  always #5 clk = ~clk;

  spike_aer_encoder #(
    .N_NEURONS  (N),
    .ADDR_W     (ADDR_W),
    .TS_W       (TS_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .spike_in   (spike_in),
    .ev_data    (ev_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .clr_flags  (clr_flags)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [EW-1:0] exp_q[$];
  bit          in_reset = 1'b1;

  // Reference model: each neuron holds at most one waiting event (its
  // timestamp), the buffer is just an occupancy number, the stream is exp_q.
  int          mdl_ts;
  bit [N-1:0]  mdl_pend;
  int          mdl_pts [N];
  int          mdl_count;
  bit          mdl_ovf;
  int          mdl_drop;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    mdl_ts = 0; mdl_pend = '0; mdl_count = 0; mdl_ovf = 0; mdl_drop = 0;
    for (int i = 0; i < N; i++) mdl_pts[i] = 0;
    exp_q.delete();
  endtask

  // Apply one clock edge's worth of the encoder rules to the model.
  task automatic mdl_edge(input logic e, input logic [N-1:0] s, input logic r, input logic c);
    bit pop, push;
    int sel, drops, base;
    bit [N-1:0] setm;
    pop = (mdl_count > 0) && r;
    sel = -1;
    for (int i = N - 1; i >= 0; i--) if (mdl_pend[i]) sel = i;
    push = (sel >= 0) && ((mdl_count < DEPTH) || pop);
    drops = 0;
    setm = '0;
    for (int i = 0; i < N; i++) begin
      if (e && s[i]) begin
        if (!mdl_pend[i] || (push && sel == i)) setm[i] = 1'b1;
        else drops++;
      end
    end
    if (push) begin
      exp_q.push_back(EW'(mdl_pts[sel] * N + sel));
      mdl_pend[sel] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (setm[i]) begin
        mdl_pend[i] = 1'b1;
        mdl_pts[i]  = mdl_ts;
      end
    end
    mdl_count = mdl_count + int'(push) - int'(pop);
    if (drops > 0) begin
      base     = c ? 0 : mdl_drop;
      mdl_drop = (base + drops > 255) ? 255 : base + drops;
      mdl_ovf  = 1'b1;
    end else if (c) begin
      mdl_ovf  = 1'b0;
      mdl_drop = 0;
    end
    if (e) mdl_ts = (mdl_ts + 1) % TS_MOD;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic e, input logic [N-1:0] s, input logic r, input logic c);
    en = e; spike_in = s; ev_ready = r; clr_flags = c;
    @(posedge clk);
    mdl_edge(e, s, r, c);
    #1;
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    rst_n = 1'b0;
    en = 1'b0; spike_in = '0; ev_ready = 1'b0; clr_flags = 1'b0;
    #1;
    check("rst_ev_valid",   ev_valid,   0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow",   overflow,   0);
    check("rst_drop_cnt",   drop_cnt,   0);
    check("rst_ev_data",    ev_data,    0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
    #1 in_reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((mdl_count != 0 || mdl_pend != '0) && n < budget) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    check("drain_in_budget", int'(mdl_count != 0 || mdl_pend != '0), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!in_reset) begin
      check("fifo_count", fifo_count, mdl_count);
      check("overflow",   overflow,   mdl_ovf);
      check("drop_cnt",   drop_cnt,   mdl_drop);
      check("ev_valid",   ev_valid,   int'(mdl_count != 0));
      if (ev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          check("ev_data", ev_data, exp_q[0]);
          if (ev_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    mdl_reset();

    // Single spike on neuron 2 at ts=5.
    do_reset();
    repeat (5) step(1'b1, '0, 1'b1, 1'b0);
    step(1'b1, 4'b0100, 1'b1, 1'b0);
    check("single_not_yet_valid", ev_valid, 0);
    step(1'b1, '0, 1'b1, 1'b0);
    check("single_valid", ev_valid, 1);
    check("single_data", ev_data, 8'h16);
    step(1'b1, '0, 1'b1, 1'b0);
    check("single_count_back", fifo_count, 0);

    // Simultaneous spikes 1011 at ts=10.
    do_reset();
    repeat (10) step(1'b1, '0, 1'b1, 1'b0);
    step(1'b1, 4'b1011, 1'b1, 1'b0);
    step(1'b1, '0, 1'b1, 1'b0);
    check("simul_ev0", ev_data, 40);
    step(1'b1, '0, 1'b1, 1'b0);
    check("simul_ev1", ev_data, 41);
    step(1'b1, '0, 1'b1, 1'b0);
    check("simul_ev3", ev_data, 43);
    drain(20);
    check("simul_no_drop", drop_cnt, 0);

    // Backpressure: 9 separated spikes on neuron 0, then a 10th is dropped.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 4'b0001, 1'b0, 1'b0);
      step(1'b1, '0, 1'b0, 1'b0);
    end
    check("bp_full", fifo_count, 8);
    check("bp_head", ev_data, 0);
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    check("bp_overflow", overflow, 1);
    check("bp_drop1", drop_cnt, 1);
    drain(30);

    // Timestamp wrap, then en=0 holds ts and ignores spikes.
    do_reset();
    repeat (66) step(1'b1, '0, 1'b1, 1'b0);
    step(1'b1, 4'b0010, 1'b1, 1'b0);
    step(1'b1, '0, 1'b1, 1'b0);
    check("wrap_data", ev_data, 9);
    repeat (10) step(1'b0, 4'($urandom_range(1, 15)), 1'b1, 1'b0);
    check("en0_no_event", ev_valid, 0);
    step(1'b1, 4'b0001, 1'b1, 1'b0);
    step(1'b1, '0, 1'b1, 1'b0);
    check("en0_ts_held", ev_data, 16);
    drain(10);

    // Drop counter saturation and clear vs drop.
    do_reset();
    repeat (80) step(1'b1, 4'b1111, 1'b0, 1'b0);
    check("sat_255", drop_cnt, 255);
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    check("sat_hold", drop_cnt, 255);
    step(1'b1, '0, 1'b0, 1'b1);
    check("clr_ovf", overflow, 0);
    check("clr_cnt", drop_cnt, 0);
    step(1'b1, 4'b0001, 1'b0, 1'b1);
    check("clr_drop_ovf", overflow, 1);
    check("clr_drop_cnt", drop_cnt, 1);
    drain(40);

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      step(logic'($urandom_range(0, 9) != 0),
           4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 49) == 0));
    end
    drain(100);
    @(negedge clk); #1;
    check("random_all_seen", exp_q.size(), 0);

    // Asynchronous reset with events queued.
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 1'b0, 1'b0);
    repeat (4) step(1'b1, '0, 1'b0, 1'b0);
    check("pre_rst_count", fifo_count, 5);
    check("pre_rst_ovf", overflow, 1);
    #2;
    do_reset();
    repeat (10) step(1'b1, '0, 1'b1, 1'b0);
    check("post_rst_idle", ev_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
